// File: rtl/bcd_display_counter.sv
// Four-digit BCD up/down counter with prescaled count steps, start/stop control,
// synchronous clear and saturating parallel load; feeds display_driver directly.
module bcd_display_counter #(
    parameter int TICK_DIV = 1000,
    parameter int DP_POS   = 2,
    parameter int INIT_RUN = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        up_dn,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic        disp_en,
    output logic        running,
    output logic        tick,
    output logic        wrap,
    output logic        bad_load
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    localparam logic STOP = 1'b0;
    localparam logic RUN  = 1'b1;
    localparam logic RESET_STATE = (INIT_RUN != 0) ? RUN : STOP;

    localparam logic [3:0] DP_MASK = (DP_POS >= 0 && DP_POS <= 3) ? 4'(1 << DP_POS) : 4'b0000;

    logic          state;
    logic          state_nxt;
    logic [PW-1:0] pre;
    logic          tick_due;
    logic [16:0]   step;
    logic [15:0]   load_sat;
    logic          load_bad;

    // Bit 16 of the result is the carry/borrow out of the top digit, i.e. a full wrap.
    function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic up);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (c) begin
                if (up) begin
                    if (v[4*i +: 4] >= 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (v[4*i +: 4] == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return {c, r};
    endfunction

    always_comb begin
        load_sat = load_val;
        load_bad = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_sat[4*i +: 4] = 4'd9;
                load_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = start_stop ? ((state == RUN) ? STOP : RUN) : state;
        tick_due  = (state == RUN) && (pre == LAST) && !clr && !load;
        step      = bcd_step(digits, up_dn);
    end

    assign dp      = DP_MASK;
    assign running = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RESET_STATE;
            pre      <= '0;
            digits   <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            bad_load <= 1'b0;
            disp_en  <= 1'b0;
        end else begin
            disp_en  <= 1'b1;
            state    <= state_nxt;
            tick     <= tick_due;
            wrap     <= tick_due & step[16];
            bad_load <= load & ~clr & load_bad;

            if (clr) begin
                digits <= '0;
            end else if (load) begin
                digits <= load_sat;
            end else if (tick_due) begin
                digits <= step[15:0];
            end

            // Prescaler is zero in any cycle spent in STOP, so a resumed run
            // always waits a full period before its first step.
            if (clr || load || tick_due || state == STOP || state_nxt == STOP) begin
                pre <= '0;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_counter.sv
// Bench for bcd_display_counter: directed scenarios with literal expectations,
// then random pulses checked every cycle against an integer-valued model.
module tb_bcd_display_counter;

    localparam int TICK_DIV = 4;
    localparam int DP_POS   = 2;
    localparam int INIT_RUN = 0;

    logic        clk;
    logic        rst;
    logic        start_stop;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic        up_dn;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        disp_en;
    logic        running;
    logic        tick;
    logic        wrap;
    logic        bad_load;

    int vectors    = 0;
    int miscompares = 0;

    bcd_display_counter #(
        .TICK_DIV (TICK_DIV),
        .DP_POS   (DP_POS),
        .INIT_RUN (INIT_RUN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .up_dn      (up_dn),
        .digits     (digits),
        .dp         (dp),
        .disp_en    (disp_en),
        .running    (running),
        .tick       (tick),
        .wrap       (wrap),
        .bad_load   (bad_load)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the displayed value is a plain integer 0..9999.
    int   m_val;
    int   m_cnt;
    logic m_run, m_tick, m_wrap, m_bad, m_en;
    logic tick_due;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int sat_val(input logic [15:0] lv);
        int acc;
        int d;
        acc = 0;
        for (int k = 3; k >= 0; k--) begin
            d = int'(lv >> (4 * k)) & 15;
            if (d > 9) d = 9;
            acc = acc * 10 + d;
        end
        return acc;
    endfunction

    function automatic logic any_bad(input logic [15:0] lv);
        logic b;
        b = 1'b0;
        for (int k = 0; k < 4; k++) if (((int'(lv) >> (4 * k)) & 15) > 9) b = 1'b1;
        return b;
    endfunction

    assign tick_due = m_run && (m_cnt == TICK_DIV - 1) && !clr && !load;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_val  <= 0;
            m_cnt  <= 0;
            m_run  <= (INIT_RUN != 0);
            m_tick <= 1'b0;
            m_wrap <= 1'b0;
            m_bad  <= 1'b0;
            m_en   <= 1'b0;
        end else begin
            m_en   <= 1'b1;
            m_run  <= m_run ^ start_stop;
            m_tick <= tick_due;
            m_wrap <= tick_due && (up_dn ? (m_val == 9999) : (m_val == 0));
            m_bad  <= load && !clr && any_bad(load_val);
            if (clr)           m_val <= 0;
            else if (load)     m_val <= sat_val(load_val);
            else if (tick_due) m_val <= up_dn ? (m_val + 1) % 10000 : (m_val + 9999) % 10000;
            if (clr || load || tick_due || !m_run || !(m_run ^ start_stop)) m_cnt <= 0;
            else m_cnt <= m_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("digits",   digits,         to_bcd(m_val));
        check("dp",       16'(dp),        16'((DP_POS <= 3) ? (1 << DP_POS) : 0));
        check("disp_en",  16'(disp_en),   16'(m_en));
        check("running",  16'(running),   16'(m_run));
        check("tick",     16'(tick),      16'(m_tick));
        check("wrap",     16'(wrap),      16'(m_wrap));
        check("bad_load", 16'(bad_load),  16'(m_bad));
    end

    // Each call is consumed by the next rising edge.
    task automatic cyc(input logic ss, input logic c, input logic l,
                       input logic [15:0] lv, input logic ud);
        @(negedge clk);
        start_stop = ss;
        clr        = c;
        load       = l;
        load_val   = lv;
        up_dn      = ud;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 16'h0000, up_dn);
    endtask

    task automatic obs();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] near [4];
        logic [15:0] lv;
        near[0] = 16'h9998; near[1] = 16'h9999; near[2] = 16'h0000; near[3] = 16'h0001;

        rst = 1'b1; start_stop = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; up_dn = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_digits",  digits,        16'h0000);
        check("rst_disp_en", 16'(disp_en),  16'h0000);
        check("rst_dp",      16'(dp),       16'h0004);

        @(negedge clk) rst = 1'b1;
        obs();
        check("en_after_release", 16'(disp_en), 16'h0001);

        // Start, then first step a full period later.
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        obs();
        check("running_on", 16'(running), 16'h0001);
        idle(3); obs();
        check("no_tick_early", 16'(tick), 16'h0000);
        idle(1); obs();
        check("first_tick", {15'b0, tick}, 16'h0001);
        check("first_val",  digits, 16'h0001);
        idle(4); obs();
        check("second_val", digits, 16'h0002);

        // Up wrap.
        cyc(1'b0, 1'b0, 1'b1, 16'h9998, 1'b1);
        idle(4); obs();
        check("up_9999", digits, 16'h9999);
        idle(4); obs();
        check("up_wrap_val",  digits, 16'h0000);
        check("up_wrap_tick", 16'(tick), 16'h0001);
        check("up_wrap_wrap", 16'(wrap), 16'h0001);

        // Down borrow ripple and down wrap.
        cyc(1'b0, 1'b0, 1'b1, 16'h1000, 1'b0);
        idle(4); obs();
        check("borrow_val",  digits, 16'h0999);
        check("borrow_wrap", 16'(wrap), 16'h0000);
        cyc(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        idle(4); obs();
        check("dn_wrap_val",  digits, 16'h9999);
        check("dn_wrap_wrap", 16'(wrap), 16'h0001);

        // Saturating load resets the prescaler.
        cyc(1'b0, 1'b0, 1'b1, 16'h1A3F, 1'b1);
        obs();
        check("sat_val", digits, 16'h1939);
        check("sat_bad", 16'(bad_load), 16'h0001);
        idle(3); obs();
        check("sat_bad_clear", 16'(bad_load), 16'h0000);
        check("sat_no_tick",   16'(tick), 16'h0000);
        idle(1); obs();
        check("sat_next", digits, 16'h1940);

        // clr beats load; stop freezes the value.
        cyc(1'b0, 1'b0, 1'b1, 16'h0042, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 16'h1A3F, 1'b1);
        obs();
        check("clr_wins_val", digits, 16'h0000);
        check("clr_wins_bad", 16'(bad_load), 16'h0000);
        check("clr_running",  16'(running), 16'h0001);
        idle(4); obs();
        check("after_clr_tick", digits, 16'h0001);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        obs();
        check("stopped", 16'(running), 16'h0000);
        idle(20); obs();
        check("frozen", digits, 16'h0001);

        // Start and load together, then asynchronous reset mid-period.
        cyc(1'b1, 1'b0, 1'b1, 16'h0123, 1'b1);
        obs();
        check("start_load_val", digits, 16'h0123);
        check("start_load_run", 16'(running), 16'h0001);
        idle(2); obs();
        #2 rst = 1'b0;
        #1;
        check("async_digits",  digits, 16'h0000);
        check("async_tick",    16'(tick), 16'h0000);
        check("async_disp_en", 16'(disp_en), 16'h0000);
        check("async_dp",      16'(dp), 16'h0004);
        @(negedge clk);
        @(negedge clk) rst = 1'b1;

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 1) == 0) lv = near[$urandom_range(0, 3)];
            else lv = 16'($urandom);
            cyc(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 99) == 0),
                1'($urandom_range(0, 29) == 0), lv,
                ($urandom_range(0, 49) == 0) ? ~up_dn : up_dn);
            if ($urandom_range(0, 799) == 0) begin
                #($urandom_range(1, 4)) rst = 1'b0;
                @(negedge clk) rst = 1'b1;
            end
        end
        idle(2);
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
